// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker and its LFSR next-word function.
package prbs_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam logic [7:0] PRBS8_TAPS = 8'hB8;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_next.sv
// Fibonacci LFSR next-word function; the all-zero word escapes to 1.
module prbs_next
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRBS8_TAPS)
) (
    input  logic [WIDTH-1:0] i_word,
    output logic [WIDTH-1:0] o_next
);

    always_comb begin
        if (i_word == '0) begin
            o_next = WIDTH'(1);
        end else begin
            o_next = {i_word[WIDTH-2:0], ^(i_word & TAPS)};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-seeding lock, flywheel prediction, error counters.
// Optional per-bit error counting is built when PRBS_CHK_BIT_ERR_EN is defined.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(PRBS8_TAPS),
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 3,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_q, have_d;
    logic [MW-1:0]    match_q, match_d;
    logic [UW-1:0]    miss_q, miss_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] exp_w;
    logic             mis;
    logic             go_lock;
    logic             go_hunt;
    logic             lk_mis;

    prbs_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next (
        .i_word (prev_q),
        .o_next (exp_w)
    );

    assign mis     = (i_data != exp_w);
    assign lk_mis  = i_valid && (state_q == LOCKED) && mis;
    assign go_lock = i_valid && (state_q == HUNT) && have_q && !mis
                     && (match_q == MW'(LOCK_CNT - 1));
    assign go_hunt = lk_mis && (miss_q == UW'(UNLOCK_CNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            prev_q  <= '0;
            have_q  <= 1'b0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            have_q  <= have_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (go_lock) begin
            state_d = LOCKED;
        end else if (go_hunt) begin
            state_d = HUNT;
        end
    end

    always_comb begin
        prev_d  = prev_q;
        have_d  = have_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (i_valid) begin
            unique case (state_q)
                HUNT: begin
                    prev_d = i_data;
                    have_d = 1'b1;
                    if (have_q) begin
                        if (go_lock) begin
                            match_d = '0;
                            miss_d  = '0;
                        end else if (!mis) begin
                            match_d = match_q + MW'(1);
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction, never the input, reseeds.
                    prev_d = exp_w;
                    if (!mis) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (go_hunt) begin
                            match_d = '0;
                            miss_d  = '0;
                            have_d  = 1'b0;
                        end else begin
                            miss_d = miss_q + UW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        if (i_clr) begin
            cnt_d = '0;
        end
    end

`ifdef PRBS_CHK_BIT_ERR_EN
    localparam int SW = CNT_W + 7;

    logic [CNT_W-1:0] bit_q, bit_d;
    logic [SW-1:0]    bit_sum;

    always_comb begin
        bit_sum = SW'(bit_q) + SW'(popcount(32'(i_data ^ exp_w)));
        bit_d   = bit_q;
        if (lk_mis) begin
            bit_d = (bit_sum > SW'({CNT_W{1'b1}})) ? '1
                                                   : bit_sum[CNT_W-1:0];
        end
        if (i_clr) begin
            bit_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q <= '0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign o_bit_err_cnt = bit_q;
`else
    assign o_bit_err_cnt = '0;
`endif

    always_comb begin
        o_locked  = (state_q == LOCKED);
        o_err     = err_q;
        o_err_cnt = cnt_q;
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: default instance plus a small-counter instance.
module tb_prbs_checker;

`ifdef PRBS_CHK_BIT_ERR_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r1 = 1'b1, v1 = 1'b0, c1 = 1'b0;
    logic [7:0]  d1 = '0;
    logic        l1, e1;
    logic [15:0] n1, b1;

    logic        r2 = 1'b1, v2 = 1'b0, c2 = 1'b0;
    logic [7:0]  d2 = '0;
    logic        l2, e2;
    logic [3:0]  n2, b2;

    int total = 0;
    int bad   = 0;

    prbs_checker u1 (
        .clk(clk), .rst(r1), .i_valid(v1), .i_data(d1), .i_clr(c1),
        .o_locked(l1), .o_err(e1), .o_err_cnt(n1), .o_bit_err_cnt(b1)
    );

    prbs_checker #(.CNT_W(4), .UNLOCK_CNT(32)) u2 (
        .clk(clk), .rst(r2), .i_valid(v2), .i_data(d2), .i_clr(c2),
        .o_locked(l2), .o_err(e2), .o_err_cnt(n2), .o_bit_err_cnt(b2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input logic r, input logic v,
                         input logic c, input logic [7:0] d);
        @(negedge clk);
        if (s == 1) begin
            r1 = r; v1 = v; c1 = c; d1 = d;
        end else begin
            r2 = r; v2 = v; c2 = c; d2 = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lock(input int s);
        drive(s, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(s, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(s, 1'b0, 1'b1, 1'b0, 8'h01);
        drive(s, 1'b0, 1'b1, 1'b0, 8'h02);
        drive(s, 1'b0, 1'b1, 1'b0, 8'h04);
        drive(s, 1'b0, 1'b1, 1'b0, 8'h08);
    endtask

    initial begin
        drive(1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_lock", 32'(l1), 0);
        chk("rst_err", 32'(e1), 0);
        chk("rst_cnt", 32'(n1), 0);
        chk("rst_bit", 32'(b1), 0);

        drive(1, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h01);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h02);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h04);
        chk("acq_pre", 32'(l1), 0);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h08);
        chk("acq_lock", 32'(l1), 1);
        chk("acq_cnt", 32'(n1), 0);

        drive(1, 1'b0, 1'b1, 1'b0, 8'h11);
        chk("se_pre_err", 32'(e1), 0);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h22);
        chk("se_err", 32'(e1), 1);
        chk("se_cnt", 32'(n1), 1);
        chk("se_bit", 32'(b1), BE ? 1 : 0);
        chk("se_lock", 32'(l1), 1);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h47);
        chk("se_fly_err", 32'(e1), 0);
        chk("se_fly_cnt", 32'(n1), 1);
        chk("se_fly_lock", 32'(l1), 1);

        lock(1);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b0, 1'b0, 1'b0, 8'h5A);
            chk("gap_err", 32'(e1), 0);
            chk("gap_lock", 32'(l1), 1);
        end
        drive(1, 1'b0, 1'b1, 1'b0, 8'h23);
        chk("gap_end_err", 32'(e1), 0);
        chk("gap_end_cnt", 32'(n1), 0);

        lock(1);
        drive(1, 1'b0, 1'b1, 1'b0, 8'hFF);
        chk("lol1_err", 32'(e1), 1);
        chk("lol1_lock", 32'(l1), 1);
        chk("lol1_bit", 32'(b1), BE ? 6 : 0);
        drive(1, 1'b0, 1'b1, 1'b0, 8'hFF);
        chk("lol2_err", 32'(e1), 1);
        chk("lol2_lock", 32'(l1), 1);
        chk("lol2_bit", 32'(b1), BE ? 11 : 0);
        drive(1, 1'b0, 1'b1, 1'b0, 8'hFF);
        chk("lol3_err", 32'(e1), 1);
        chk("lol3_lock", 32'(l1), 0);
        chk("lol3_cnt", 32'(n1), 3);
        chk("lol3_bit", 32'(b1), BE ? 15 : 0);
        drive(1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_cnt", 32'(n1), 0);
        chk("clr_bit", 32'(b1), 0);
        chk("clr_err", 32'(e1), 0);
        chk("clr_lock", 32'(l1), 0);

        lock(1);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h47);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h38);
        chk("ml_match", 32'(e1), 0);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ml_cnt", 32'(n1), 5);
        chk("ml_lock", 32'(l1), 1);
        drive(1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("mr_lock", 32'(l1), 0);
        chk("mr_err", 32'(e1), 0);
        chk("mr_cnt", 32'(n1), 0);
        chk("mr_bit", 32'(b1), 0);
        drive(1, 1'b0, 1'b1, 1'b0, 8'hE2);
        chk("mr_seed_err", 32'(e1), 0);
        chk("mr_seed_lock", 32'(l1), 0);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00);

        lock(2);
        chk("sat_lock0", 32'(l2), 1);
        for (int i = 0; i < 20; i++) begin
            drive(2, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("sat_err", 32'(e2), 1);
            chk("sat_cnt", 32'(n2), (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_lock", 32'(l2), 1);
        chk("sat_bit", 32'(b2), BE ? 15 : 0);
        drive(2, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("satclr_cnt", 32'(n2), 0);
        chk("satclr_bit", 32'(b2), 0);
        chk("satclr_err", 32'(e2), 1);
        chk("satclr_lock", 32'(l2), 1);
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
